// File: rtl/qos_vc_arbiter_if.sv
// Handshake bundle between the VC FIFO bank / egress FIFO and qos_vc_arbiter.
// master = arbiter side, slave = FIFO side.
interface qos_vc_arbiter_if;
  logic        ENABLE;
  logic [3:0]  EMPTY_VC;
  logic [15:0] DATO_VC;
  logic        OUT_FULL;
  logic        OUT_ALMOST_FULL;
  logic [3:0]  POP_VC;
  logic        PUSH_OUT;
  logic [3:0]  DATO_OUT;
  logic [1:0]  VC_OUT;
  logic [6:0]  TL_OUT;
  logic [6:0]  TH_OUT;
  logic        ACTIVE;

  modport master (
    input  ENABLE, EMPTY_VC, DATO_VC, OUT_FULL, OUT_ALMOST_FULL,
    output POP_VC, PUSH_OUT, DATO_OUT, VC_OUT, TL_OUT, TH_OUT, ACTIVE
  );
  modport slave (
    output ENABLE, EMPTY_VC, DATO_VC, OUT_FULL, OUT_ALMOST_FULL,
    input  POP_VC, PUSH_OUT, DATO_OUT, VC_OUT, TL_OUT, TH_OUT, ACTIVE
  );
endinterface

// File: rtl/qos_vc_arbiter.sv
// Weighted round-robin drain of four VC FIFOs into one egress FIFO, 1-cycle pop-to-push.
// Optional macro QOS_STRICT_PRIO_EN: VC3 becomes strict priority, WRR over VC0-VC2.
module qos_vc_arbiter #(
  parameter logic [3:0] W0     = 4'd1,
  parameter logic [3:0] W1     = 4'd2,
  parameter logic [3:0] W2     = 4'd3,
  parameter logic [3:0] W3     = 4'd4,
  parameter logic [6:0] OUT_TL = 7'd1,
  parameter logic [6:0] OUT_TH = 7'd6
) (
  input logic             CLOCK,
  input logic             RESET,
  qos_vc_arbiter_if.master bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  function automatic logic [3:0] eff(input logic [3:0] w);
    return (w == 4'd0) ? 4'd1 : w;
  endfunction

  // First set bit of m at or after s, wrapping 3->0.
  function automatic logic [1:0] first_from(input logic [3:0] m, input logic [1:0] s);
    logic [1:0] r, k;
    r = s;
    for (int i = 3; i >= 0; i--) begin
      k = s + 2'(i);
      if (m[k]) r = k;
    end
    return r;
  endfunction

  logic [3:0][3:0] weff;
  logic [0:0]      state, state_n;
  logic [1:0]      cur, cur_n, pop_idx, vc_q;
  logic [3:0]      cnt, cnt_n, elig, wrr_elig;
  logic            ok, prio, pop_go, push_q;

  assign weff = {eff(W3), eff(W2), eff(W1), eff(W0)};
  assign elig = ~bus.EMPTY_VC;
  assign ok   = bus.ENABLE & ~bus.OUT_FULL & ~bus.OUT_ALMOST_FULL;

`ifdef QOS_STRICT_PRIO_EN
  assign wrr_elig = {1'b0, elig[2:0]};
  assign prio     = elig[3] & ok;
`else
  assign wrr_elig = elig;
  assign prio     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    pop_go  = 1'b0;
    pop_idx = cur;
    if (prio) begin
      // strict VC3 steals the slot without touching the WRR turn
      pop_go  = 1'b1;
      pop_idx = 2'd3;
    end else if (state == IDLE) begin
      if (ok && |wrr_elig) begin
        pop_go  = 1'b1;
        pop_idx = first_from(wrr_elig, cur);
        cur_n   = pop_idx;
        cnt_n   = 4'd1;
        state_n = SERVE;
      end
    end else begin
      if (!(|wrr_elig)) begin
        state_n = IDLE;
        cur_n   = cur + 2'd1;
      end else if (ok) begin
        pop_go = 1'b1;
        if (wrr_elig[cur] && cnt < weff[cur]) begin
          pop_idx = cur;
          cnt_n   = (cnt == 4'hF) ? cnt : cnt + 4'd1;
        end else begin
          // wraps back onto cur when it is the only eligible VC
          pop_idx = first_from(wrr_elig, cur + 2'd1);
          cur_n   = pop_idx;
          cnt_n   = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state  <= IDLE;
      cur    <= 2'd0;
      cnt    <= 4'd0;
      push_q <= 1'b0;
      vc_q   <= 2'd0;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      cnt    <= cnt_n;
      push_q <= pop_go;
      if (pop_go) vc_q <= pop_idx;
    end
  end

  // Outputs are forced quiet while RESET is held so a pending push is dropped.
  assign bus.POP_VC   = (pop_go && !RESET) ? (4'b0001 << pop_idx) : 4'b0000;
  assign bus.PUSH_OUT = push_q & ~RESET;
  assign bus.DATO_OUT = bus.PUSH_OUT ? bus.DATO_VC[{vc_q, 2'b00} +: 4] : 4'd0;
  assign bus.VC_OUT   = vc_q;
  assign bus.ACTIVE   = (state == SERVE) & ~RESET;
  assign bus.TL_OUT   = OUT_TL;
  assign bus.TH_OUT   = OUT_TH;
endmodule

// File: tb/tb_qos_vc_arbiter.sv
// Directed table-driven bench for qos_vc_arbiter with a counting model of the VC FIFOs.
module tb_qos_vc_arbiter;
  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  qos_vc_arbiter_if bus();

  qos_vc_arbiter dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit              ld;
    logic [3:0][7:0] c;
    bit              rst, en, af, fl;
    logic [3:0]      pop;
    bit              push;
    logic [1:0]      vc;
    bit              act;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   fcnt[4];
  vec_t tbl[$];

  function automatic vec_t r(bit rst, bit en, bit af, bit fl, logic [3:0] pop,
                             bit push, logic [1:0] vc, bit act);
    vec_t v;
    v.ld = 1'b0; v.c = '0;
    v.rst = rst; v.en = en; v.af = af; v.fl = fl;
    v.pop = pop; v.push = push; v.vc = vc; v.act = act;
    return v;
  endfunction

  function automatic vec_t n(logic [3:0] pop, bit push, logic [1:0] vc, bit act);
    return r(1'b0, 1'b1, 1'b0, 1'b0, pop, push, vc, act);
  endfunction

  // Reset row that also preloads the FIFO word counts.
  function automatic vec_t rl(logic [7:0] c0, logic [7:0] c1, logic [7:0] c2, logic [7:0] c3);
    vec_t v;
    v = r(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
    v.ld = 1'b1; v.c = {c3, c2, c1, c0};
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(vec_t v, int idx);
    logic [3:0] p;
    if (v.ld) for (int k = 0; k < 4; k++) fcnt[k] = int'(v.c[k]);
    RESET               = v.rst;
    bus.ENABLE          = v.en;
    bus.OUT_ALMOST_FULL = v.af;
    bus.OUT_FULL        = v.fl;
    for (int k = 0; k < 4; k++) bus.EMPTY_VC[k] = (fcnt[k] == 0);
    #3;
    p = bus.POP_VC;
    chk("pop_vc", idx, 32'(p), 32'(v.pop));
    chk("push_out", idx, 32'(bus.PUSH_OUT), 32'(v.push));
    if (v.push) begin
      chk("vc_out", idx, 32'(bus.VC_OUT), 32'(v.vc));
      chk("dato_out", idx, 32'(bus.DATO_OUT), 32'(4'd6 + 4'(v.vc)));
    end else begin
      chk("dato_idle", idx, 32'(bus.DATO_OUT), 32'd0);
    end
    chk("active", idx, 32'(bus.ACTIVE), 32'(v.act));
    chk("tl_out", idx, 32'(bus.TL_OUT), 32'd1);
    chk("th_out", idx, 32'(bus.TH_OUT), 32'd6);
    @(posedge CLOCK);
    for (int k = 0; k < 4; k++) if (p[k] && fcnt[k] > 0) fcnt[k]--;
    #1;
  endtask

  initial begin
    vec_t h;
    bus.ENABLE = 1'b1; bus.OUT_FULL = 1'b0; bus.OUT_ALMOST_FULL = 1'b0;
    bus.EMPTY_VC = 4'hF;
    bus.DATO_VC = 16'h9876; // VCn word = 6+n
    for (int k = 0; k < 4; k++) fcnt[k] = 0;

    // reset held two cycles with data present
    tbl.push_back(rl(5, 5, 5, 5));
    tbl.push_back(r(1, 1, 0, 0, 4'b0000, 0, 0, 0));
`ifndef QOS_STRICT_PRIO_EN
    // steady WRR 1/2/3/4
    tbl.push_back(rl(50, 50, 50, 50));
    tbl.push_back(n(4'b0001, 0, 0, 0));
    tbl.push_back(n(4'b0010, 1, 0, 1));
    tbl.push_back(n(4'b0010, 1, 1, 1));
    tbl.push_back(n(4'b0100, 1, 1, 1));
    tbl.push_back(n(4'b0100, 1, 2, 1));
    tbl.push_back(n(4'b0100, 1, 2, 1));
    tbl.push_back(n(4'b1000, 1, 2, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b0001, 1, 3, 1));
    tbl.push_back(n(4'b0010, 1, 0, 1));
    tbl.push_back(n(4'b0010, 1, 1, 1));
    // reset right after a pop: that push is dropped
    tbl.push_back(rl(0, 50, 0, 50));
    // sparse VC1/VC3 with wrap
    tbl.push_back(n(4'b0010, 0, 0, 0));
    tbl.push_back(n(4'b0010, 1, 1, 1));
    tbl.push_back(n(4'b1000, 1, 1, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b0010, 1, 3, 1));
    tbl.push_back(n(4'b0010, 1, 1, 1));
    tbl.push_back(n(4'b1000, 1, 1, 1));
    // backpressure mid VC2 turn, then ENABLE drop
    tbl.push_back(rl(50, 50, 50, 50));
    tbl.push_back(n(4'b0001, 0, 0, 0));
    tbl.push_back(n(4'b0010, 1, 0, 1));
    tbl.push_back(n(4'b0010, 1, 1, 1));
    tbl.push_back(n(4'b0100, 1, 1, 1));
    tbl.push_back(n(4'b0100, 1, 2, 1));
    tbl.push_back(r(0, 1, 1, 0, 4'b0000, 1, 2, 1));
    tbl.push_back(r(0, 1, 1, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(r(0, 1, 0, 1, 4'b0000, 0, 0, 1));
    tbl.push_back(r(0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(n(4'b0100, 0, 0, 1));
    tbl.push_back(n(4'b1000, 1, 2, 1));
    tbl.push_back(r(0, 0, 0, 0, 4'b0000, 1, 3, 1));
    tbl.push_back(r(0, 0, 0, 0, 4'b0000, 0, 0, 1));
    tbl.push_back(n(4'b1000, 0, 0, 1));
    // lone VC3 keeps being served after its credit runs out
    tbl.push_back(rl(0, 0, 0, 50));
    tbl.push_back(n(4'b1000, 0, 0, 0));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
`else
    // VC3 strict: interrupts VC2's turn, then VC2 resumes at cnt=2
    tbl.push_back(rl(50, 50, 50, 0));
    tbl.push_back(n(4'b0001, 0, 0, 0));
    tbl.push_back(n(4'b0010, 1, 0, 1));
    tbl.push_back(n(4'b0010, 1, 1, 1));
    tbl.push_back(n(4'b0100, 1, 1, 1));
    h = n(4'b1000, 1, 2, 1);
    h.ld = 1'b1; h.c = {8'd3, 8'd49, 8'd48, 8'd49};
    tbl.push_back(h);
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b1000, 1, 3, 1));
    tbl.push_back(n(4'b0100, 1, 3, 1));
    tbl.push_back(n(4'b0100, 1, 2, 1));
    tbl.push_back(n(4'b0001, 1, 2, 1));
    tbl.push_back(n(4'b0010, 1, 0, 1));
`endif

    @(posedge CLOCK); #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // single word in VC0 (W0=1): one pop, back to IDLE, then IDLE resumes from cur=1
    step(rl(1, 0, 0, 0), 100);
    step(n(4'b0001, 0, 0, 0), 101);
    step(n(4'b0000, 1, 0, 1), 102);
    step(n(4'b0000, 0, 0, 0), 103);
    step(n(4'b0000, 0, 0, 0), 104);
    h = n(4'b0001, 0, 0, 0);
    h.ld = 1'b1; h.c = {8'd0, 8'd0, 8'd0, 8'd1};
    step(h, 105);
    step(n(4'b0000, 1, 0, 1), 106);
    step(n(4'b0000, 0, 0, 0), 107);

    // reset in the cycle after a pop: no push and no further pops
    step(rl(9, 9, 9, 0), 110);
    step(n(4'b0001, 0, 0, 0), 111);
    step(r(1, 1, 0, 0, 4'b0000, 0, 0, 0), 112);
    step(r(1, 1, 0, 0, 4'b0000, 0, 0, 0), 113);
    step(n(4'b0001, 0, 0, 0), 114);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
